// File: rtl/lfsr_state_decoder_pkg.sv
// Shared definitions for the LFSR state decoder: FSM encoding and the Galois forward step.
// The forward step is the golden reference for both the decoder datapath and its benches.
package pkg_lfsr_dec;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } dec_state_e;

    // One Galois step of a w-bit register held in the low bits of a 64-bit word.
    function automatic logic [63:0] lfsr_fwd(input logic [63:0] n, input logic [63:0] poly,
                                             input int w);
        logic [63:0] low_mask;
        logic [63:0] msb_v;
        logic [63:0] low;
        low_mask = (64'd1 << (w - 1)) - 64'd1;
        msb_v    = n >> (w - 1);
        low      = n & low_mask;
        if (!msb_v[0]) begin
            low = low ^ (poly & low_mask);
        end
        return (low << 1) | {63'd0, msb_v[0]};
    endfunction

endpackage

// File: rtl/lfsr_state_decoder.sv
// Iterative Galois-LFSR state decoder: returns the number of forward steps to reach zero.
// Optional macro LFSR_DEC_TWO_STEP_EN advances the register two steps per RUN cycle.
module lfsr_state_decoder
    import pkg_lfsr_dec::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] POLY  = 8'hb8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_state,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_count,
    output logic             m_err
);

    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] CNT_MAX  = ALL_ONES - ONE;

    function automatic logic [WIDTH-1:0] fwd(input logic [WIDTH-1:0] n);
        logic [63:0] r;
        r = lfsr_fwd(64'(n), 64'(POLY), WIDTH);
        return r[WIDTH-1:0];
    endfunction

    dec_state_e       state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] m_count_q, m_count_d;
    logic             m_err_q, m_err_d;
    logic [WIDTH-1:0] step1;
    logic [WIDTH-1:0] cnt_inc1;
`ifdef LFSR_DEC_TWO_STEP_EN
    logic [WIDTH-1:0] step2;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            sreg_q    <= '0;
            cnt_q     <= '0;
            m_count_q <= '0;
            m_err_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            sreg_q    <= sreg_d;
            cnt_q     <= cnt_d;
            m_count_q <= m_count_d;
            m_err_q   <= m_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sreg_d    = sreg_q;
        cnt_d     = cnt_q;
        m_count_d = m_count_q;
        m_err_d   = m_err_q;
        step1     = fwd(sreg_q);
        cnt_inc1  = cnt_q + ONE;
`ifdef LFSR_DEC_TWO_STEP_EN
        step2     = fwd(step1);
`endif
        case (state_q)
            IDLE: begin
                if (s_valid) begin
                    sreg_d = s_state;
                    cnt_d  = '0;
                    // All-ones maps to itself and can never reach zero.
                    if (s_state == ALL_ONES) begin
                        state_d   = DONE;
                        m_count_d = '0;
                        m_err_d   = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (sreg_q == '0) begin
                    state_d   = DONE;
                    m_count_d = cnt_q;
                    m_err_d   = 1'b0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d   = DONE;
                    m_count_d = cnt_q;
                    m_err_d   = 1'b1;
                end else begin
`ifdef LFSR_DEC_TWO_STEP_EN
                    // Halt after the first step if it hits zero or the step budget.
                    if ((step1 == '0) || (cnt_inc1 == CNT_MAX)) begin
                        sreg_d = step1;
                        cnt_d  = cnt_inc1;
                    end else begin
                        sreg_d = step2;
                        cnt_d  = cnt_inc1 + ONE;
                    end
`else
                    sreg_d = step1;
                    cnt_d  = cnt_inc1;
`endif
                end
            end
            DONE: begin
                if (m_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign s_ready = (state_q == IDLE) & ~rst;
    assign m_valid = (state_q == DONE);
    assign m_count = m_count_q;
    assign m_err   = m_err_q;

endmodule
